// File: rtl/ibex_hpm_counters.sv
// Machine performance-counter bank: mcycle, minstret, mhpmcounter3+ with
// event selection, mcountinhibit gating and per-counter overflow pulses.
// Reads are combinational from the current register state; every update
// lands on the next rising edge of clk_i.

// One mhpmcounter lane: its event-select mask, W-bit counter and overflow flag.
module ibex_hpm_lane #(
  parameter int unsigned W = 40,
  parameter int unsigned E = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         i_evt_we,
  input  logic         i_lo_we,
  input  logic         i_hi_we,
  input  logic [31:0]  i_wdata,
  input  logic [E-1:0] i_events,
  input  logic         i_inhibit,
  output logic [W-1:0] o_cnt,
  output logic [E-1:0] o_evt,
  output logic         o_ovf
);

  logic [E-1:0] r_evt;
  logic [W-1:0] r_cnt;
  logic         r_ovf;
  logic         w_inc;
  logic         w_wr;

  // Increment decision uses the mask/inhibit values held this cycle, so a
  // config write only affects the following cycle.
  assign w_inc = (|(i_events & r_evt)) & ~i_inhibit;
  assign w_wr  = i_lo_we | i_hi_we;

  // Event-select mask register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)       r_evt <= '0;
    else if (i_evt_we) r_evt <= i_wdata[E-1:0];
  end

  // Counter: a write to either half wins over the increment and does not
  // carry into the untouched half.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)      r_cnt <= '0;
    else if (i_lo_we) r_cnt[31:0] <= i_wdata;
    else if (i_hi_we) r_cnt[W-1:32] <= i_wdata[W-33:0];
    else if (w_inc)   r_cnt <= r_cnt + W'(1);
  end

  // Overflow pulse for the cycle after an all-ones increment; writes never pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_ovf <= 1'b0;
    else         r_ovf <= w_inc & ~w_wr & (&r_cnt);
  end

  assign o_cnt = r_cnt;
  assign o_evt = r_evt;
  assign o_ovf = r_ovf;

endmodule

module ibex_hpm_counters #(
  parameter int unsigned MHPMCounterNum   = 8,
  parameter int unsigned MHPMCounterWidth = 40,
  parameter int unsigned NumEvents        = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [11:0]               csr_addr_i,
  input  logic                      csr_we_i,
  input  logic [31:0]               csr_wdata_i,
  output logic [31:0]               csr_rdata_o,
  output logic                      csr_hit_o,
  input  logic                      instr_ret_i,
  input  logic [NumEvents-1:0]      events_i,
  output logic [MHPMCounterNum-1:0] cnt_overflow_o
);

  localparam int unsigned NI = (MHPMCounterNum == 0) ? 1 : MHPMCounterNum;
  localparam int unsigned W  = MHPMCounterWidth;
  localparam int unsigned E  = NumEvents;

  // Implemented mcountinhibit bits: CY, IR and one per mhpmcounter.
  function automatic logic [31:0] inh_mask();
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int k = 0; k < int'(MHPMCounterNum); k++) m[3+k] = 1'b1;
    return m;
  endfunction

  localparam logic [31:0] INH_MASK = inh_mask();

  logic [4:0]             w_idx;
  logic                   w_sel_cfg;
  logic                   w_sel_lo;
  logic                   w_sel_hi;
  logic                   w_we_inh;
  logic                   w_we_cy_lo, w_we_cy_hi;
  logic                   w_we_ir_lo, w_we_ir_hi;
  logic [31:0]            r_inhibit;
  logic [63:0]            r_mcycle;
  logic [63:0]            r_minstret;
  logic [NI-1:0][W-1:0]   w_cnt;
  logic [NI-1:0][31:0]    w_cnt_hi;
  logic [NI-1:0][E-1:0]   w_evt;
  logic [NI-1:0]          w_ovf;
  logic [31:0]            w_rdata;

  // Three 32-entry windows: 0x320 config, 0xB00 low halves, 0xB80 high halves.
  assign w_idx     = csr_addr_i[4:0];
  assign w_sel_cfg = (csr_addr_i[11:5] == 7'b0011001);
  assign w_sel_lo  = (csr_addr_i[11:5] == 7'b1011000);
  assign w_sel_hi  = (csr_addr_i[11:5] == 7'b1011100);
  assign csr_hit_o = w_sel_cfg | w_sel_lo | w_sel_hi;

  assign w_we_inh   = csr_we_i & w_sel_cfg & (w_idx == 5'd0);
  assign w_we_cy_lo = csr_we_i & w_sel_lo  & (w_idx == 5'd0);
  assign w_we_cy_hi = csr_we_i & w_sel_hi  & (w_idx == 5'd0);
  assign w_we_ir_lo = csr_we_i & w_sel_lo  & (w_idx == 5'd2);
  assign w_we_ir_hi = csr_we_i & w_sel_hi  & (w_idx == 5'd2);

  // mcountinhibit: unimplemented bits are masked off on write.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)       r_inhibit <= '0;
    else if (w_we_inh) r_inhibit <= csr_wdata_i & INH_MASK;
  end

  // mcycle: free-running unless inhibited; half writes override the increment.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)           r_mcycle <= '0;
    else if (w_we_cy_lo)   r_mcycle[31:0]  <= csr_wdata_i;
    else if (w_we_cy_hi)   r_mcycle[63:32] <= csr_wdata_i;
    else if (!r_inhibit[0]) r_mcycle <= r_mcycle + 64'd1;
  end

  // minstret: counts retirements unless inhibited.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                         r_minstret <= '0;
    else if (w_we_ir_lo)                 r_minstret[31:0]  <= csr_wdata_i;
    else if (w_we_ir_hi)                 r_minstret[63:32] <= csr_wdata_i;
    else if (instr_ret_i && !r_inhibit[2]) r_minstret <= r_minstret + 64'd1;
  end

  // Per-counter lanes.
  generate
    if (MHPMCounterNum == 0) begin : g_no_lanes
      assign w_cnt          = '0;
      assign w_cnt_hi       = '0;
      assign w_evt          = '0;
      assign w_ovf          = '0;
      assign cnt_overflow_o = '0;
    end else begin : g_lanes
      for (genvar i = 0; i < int'(MHPMCounterNum); i++) begin : g_lane
        logic w_evt_we, w_lo_we, w_hi_we;
        assign w_evt_we = csr_we_i & w_sel_cfg & (w_idx == 5'(i + 3));
        assign w_lo_we  = csr_we_i & w_sel_lo  & (w_idx == 5'(i + 3));
        assign w_hi_we  = csr_we_i & w_sel_hi  & (w_idx == 5'(i + 3));

        ibex_hpm_lane #(
          .W (W),
          .E (E)
        ) u_lane (
          .clk_i     (clk_i),
          .rst_ni    (rst_ni),
          .i_evt_we  (w_evt_we),
          .i_lo_we   (w_lo_we),
          .i_hi_we   (w_hi_we),
          .i_wdata   (csr_wdata_i),
          .i_events  (events_i),
          .i_inhibit (r_inhibit[3+i]),
          .o_cnt     (w_cnt[i]),
          .o_evt     (w_evt[i]),
          .o_ovf     (w_ovf[i])
        );

        // High half is zero-extended to 32 bits.
        assign w_cnt_hi[i] = 32'(w_cnt[i][W-1:32]);
      end
      assign cnt_overflow_o = w_ovf;
    end
  endgenerate

  // Read mux: unimplemented slots and out-of-range addresses read zero.
  always_comb begin
    w_rdata = '0;
    if (w_sel_cfg) begin
      if (w_idx == 5'd0) w_rdata = r_inhibit;
      for (int i = 0; i < int'(MHPMCounterNum); i++)
        if (w_idx == 5'(i + 3)) w_rdata = 32'(w_evt[i]);
    end
    if (w_sel_lo) begin
      if (w_idx == 5'd0) w_rdata = r_mcycle[31:0];
      if (w_idx == 5'd2) w_rdata = r_minstret[31:0];
      for (int i = 0; i < int'(MHPMCounterNum); i++)
        if (w_idx == 5'(i + 3)) w_rdata = w_cnt[i][31:0];
    end
    if (w_sel_hi) begin
      if (w_idx == 5'd0) w_rdata = r_mcycle[63:32];
      if (w_idx == 5'd2) w_rdata = r_minstret[63:32];
      for (int i = 0; i < int'(MHPMCounterNum); i++)
        if (w_idx == 5'(i + 3)) w_rdata = w_cnt_hi[i];
    end
  end

  assign csr_rdata_o = w_rdata;

endmodule

// File: tb/tb_ibex_hpm_counters.sv
// Bench for ibex_hpm_counters: directed scenarios plus randomized CSR and
// event traffic against a behavioural model; a monitor checks every cycle.
module tb_ibex_hpm_counters;
  localparam int N = 8;
  localparam int W = 40;
  localparam int E = 16;
  localparam longint unsigned WMASK = (64'd1 << W) - 64'd1;
  localparam longint unsigned LO32  = 64'h0000_0000_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [11:0]  csr_addr = '0;
  logic         csr_we = 1'b0;
  logic [31:0]  csr_wdata = '0;
  logic [31:0]  csr_rdata;
  logic         csr_hit;
  logic         instr_ret = 1'b0;
  logic [E-1:0] events = '0;
  logic [N-1:0] ovf;

  always #5 clk = ~clk;

  ibex_hpm_counters #(
    .MHPMCounterNum   (N),
    .MHPMCounterWidth (W),
    .NumEvents        (E)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .csr_addr_i     (csr_addr),
    .csr_we_i       (csr_we),
    .csr_wdata_i    (csr_wdata),
    .csr_rdata_o    (csr_rdata),
    .csr_hit_o      (csr_hit),
    .instr_ret_i    (instr_ret),
    .events_i       (events),
    .cnt_overflow_o (ovf)
  );

  typedef struct {
    logic         hit;
    logic [31:0]  rd;
    logic [N-1:0] ovf;
    string        tag;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   ovf_seen = 0;

  // Reference state, kept as plain integers.
  longint unsigned m_cy, m_ir;
  longint unsigned m_hpm[N];
  logic [31:0]     m_evt[N];
  logic [31:0]     m_inh;
  logic [N-1:0]    m_ovf;

  function automatic logic m_hit(input logic [11:0] a);
    return (a >= 12'h320 && a <= 12'h33F) || (a >= 12'hB00 && a <= 12'hB1F) ||
           (a >= 12'hB80 && a <= 12'hB9F);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    int k;
    k = int'(a[4:0]) - 3;
    if (a == 12'h320) return m_inh;
    if (a == 12'hB00) return m_cy[31:0];
    if (a == 12'hB80) return m_cy[63:32];
    if (a == 12'hB02) return m_ir[31:0];
    if (a == 12'hB82) return m_ir[63:32];
    if (k >= 0 && k < N) begin
      if (a[11:5] == 7'b0011001) return m_evt[k];
      if (a[11:5] == 7'b1011000) return m_hpm[k][31:0];
      if (a[11:5] == 7'b1011100) return 32'(m_hpm[k] >> 32);
    end
    return 32'd0;
  endfunction

  task automatic m_step(input logic rst, input logic [11:0] a, input logic we,
                        input logic [31:0] wd, input logic [E-1:0] ev, input logic ret);
    logic [N-1:0] nov;
    bit inc;
    nov = '0;
    if (!rst) begin
      m_cy = 0; m_ir = 0; m_inh = '0; m_ovf = '0;
      for (int k = 0; k < N; k++) begin m_hpm[k] = 0; m_evt[k] = '0; end
      return;
    end
    for (int k = 0; k < N; k++) begin
      inc = ((ev & m_evt[k][E-1:0]) != '0) && !m_inh[3+k];
      if (we && int'(a) == 'hB03 + k)
        m_hpm[k] = (m_hpm[k] & ~LO32) | longint'(wd);
      else if (we && int'(a) == 'hB83 + k)
        m_hpm[k] = ((longint'(wd) << 32) & WMASK) | (m_hpm[k] & LO32);
      else if (inc) begin
        if (m_hpm[k] == WMASK) nov[k] = 1'b1;
        m_hpm[k] = (m_hpm[k] + 1) & WMASK;
      end
    end
    if (we && a == 12'hB00)      m_cy = (m_cy & ~LO32) | longint'(wd);
    else if (we && a == 12'hB80) m_cy = (longint'(wd) << 32) | (m_cy & LO32);
    else if (!m_inh[0])          m_cy = m_cy + 1;
    if (we && a == 12'hB02)      m_ir = (m_ir & ~LO32) | longint'(wd);
    else if (we && a == 12'hB82) m_ir = (longint'(wd) << 32) | (m_ir & LO32);
    else if (ret && !m_inh[2])   m_ir = m_ir + 1;
    // Config writes are applied after this cycle's increment decisions.
    for (int k = 0; k < N; k++)
      if (we && int'(a) == 'h323 + k) m_evt[k] = wd & 32'h0000_FFFF;
    if (we && a == 12'h320) m_inh = wd & 32'h0000_07FD;
    m_ovf = nov;
  endtask

  // One clock cycle of stimulus; the expected response goes to the scoreboard.
  task automatic cyc(input logic rst, input logic [11:0] a, input logic we,
                     input logic [31:0] wd, input logic [E-1:0] ev, input logic ret,
                     input bit fix, input logic [31:0] fixv, input string tag);
    exp_t e;
    rst_n = rst; csr_addr = a; csr_we = we; csr_wdata = wd; events = ev; instr_ret = ret;
    e.hit = m_hit(a);
    e.rd  = fix ? fixv : m_read(a);
    e.ovf = m_ovf;
    e.tag = tag;
    sbq.push_back(e);
    m_step(rst, a, we, wd, ev, ret);
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] v, input string tag,
                    input logic [E-1:0] ev = '0);
    cyc(1'b1, a, 1'b0, 32'd0, ev, 1'b0, 1'b1, v, tag);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [E-1:0] ev = '0);
    cyc(1'b1, a, 1'b1, d, ev, 1'b0, 1'b0, 32'd0, "wr");
  endtask

  task automatic idle(input logic [E-1:0] ev = '0);
    cyc(1'b1, 12'h000, 1'b0, 32'd0, ev, 1'b0, 1'b0, 32'd0, "idle");
  endtask

  // Monitor: compare what the DUT presents this cycle against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ovf[0] === 1'b1) ovf_seen++;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_chk++;
        if (csr_hit !== e.hit) begin
          n_fail++;
          $display("FAIL %s hit addr=%h got %b exp %b", e.tag, csr_addr, csr_hit, e.hit);
        end
        n_chk++;
        if (csr_rdata !== e.rd) begin
          n_fail++;
          $display("FAIL %s rdata addr=%h got %h exp %h", e.tag, csr_addr, csr_rdata, e.rd);
        end
        n_chk++;
        if (ovf !== e.ovf) begin
          n_fail++;
          $display("FAIL %s ovf got %b exp %b", e.tag, ovf, e.ovf);
        end
      end
    end
  end

  initial begin
    logic [11:0] a;
    logic [31:0] d;
    m_step(1'b0, 12'h0, 1'b0, 32'd0, '0, 1'b0);
    @(posedge clk); #1;
    cyc(1'b0, 12'h000, 1'b0, 32'd0, '0, 1'b0, 1'b0, 32'd0, "reset");
    cyc(1'b0, 12'hB00, 1'b1, 32'hDEAD, 16'hFFFF, 1'b1, 1'b0, 32'd0, "reset_wr");

    // Reset and free run.
    for (int i = 0; i < 10; i++) idle();
    rd(12'hB00, 32'd10, "t1_mcycle");
    rd(12'hB02, 32'd0,  "t1_minstret");
    for (int k = 0; k < N; k++) rd(12'(12'hB03 + k), 32'd0, "t1_hpm");

    // Event selection.
    wr(12'h323, 32'h5);
    idle(16'h0001); idle(16'h0002); idle(16'h0004); idle(16'h0005);
    rd(12'hB03, 32'd3, "t2_hpm3");
    rd(12'hB04, 32'd0, "t2_hpm4");
    rd(12'h323, 32'd5, "t2_evt3");

    // Inhibit.
    wr(12'h320, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) idle(16'hFFFF);
    rd(12'h320, 32'h0000_07FD, "t3_inh");
    rd(12'hB00, 32'(m_cy), "t3_mcycle_frozen");

    // Width and wrap.
    wr(12'h320, 32'h0);
    wr(12'hB83, 32'hFFFF_FFFF);
    wr(12'hB03, 32'hFFFF_FFFE);
    rd(12'hB83, 32'h0000_00FF, "t4_hi_trunc");
    ovf_seen = 0;
    idle(16'h0001); idle(16'h0001);
    rd(12'hB83, 32'd0, "t4_hi_wrap");
    rd(12'hB03, 32'd0, "t4_lo_wrap");
    idle();
    n_chk++;
    if (ovf_seen != 1) begin
      n_fail++;
      $display("FAIL t4_ovf_pulse_cycles got %0d exp 1", ovf_seen);
    end

    // Write/increment collision.
    wr(12'hB03, 32'h100, 16'h0001);
    rd(12'hB03, 32'h100, "t5_wr_wins", 16'h0001);
    rd(12'hB03, 32'h101, "t5_inc_after", 16'h0001);

    // Back-to-back low/high writes with increments in between.
    wr(12'hB03, 32'hFFFF_FFFF, 16'h0001);
    wr(12'hB83, 32'h12, 16'h0001);
    rd(12'hB83, 32'h12, "b2b_hi", 16'h0001);
    rd(12'hB03, 32'h0,  "b2b_lo_inc");
    rd(12'hB83, 32'h13, "b2b_hi_carry");

    // Unmapped and unimplemented slots.
    wr(12'hB1F, 32'hFFFF_FFFF); rd(12'hB1F, 32'd0, "t6_b1f");
    wr(12'h33F, 32'hFFFF_FFFF); rd(12'h33F, 32'd0, "t6_33f");
    wr(12'hB0B, 32'hFFFF_FFFF); rd(12'hB0B, 32'd0, "t6_b0b");
    wr(12'h300, 32'hFFFF_FFFF); rd(12'h300, 32'd0, "t6_300");
    rd(12'h321, 32'd0, "t6_321");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0: a = 12'h320;
        1: a = 12'(12'h323 + $urandom_range(0, 9));
        2: a = 12'hB00;
        3: a = 12'hB80;
        4: a = 12'(12'hB02 + 12'($urandom_range(0, 1)) * 12'h80);
        5, 6: a = 12'(12'hB03 + $urandom_range(0, 9));
        7, 8: a = 12'(12'hB83 + $urandom_range(0, 9));
        default: a = 12'($urandom());
      endcase
      case ($urandom_range(0, 3))
        0: d = $urandom();
        1: d = 32'hFFFF_FFFF;
        2: d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: d = 32'($urandom_range(0, 15));
      endcase
      cyc(($urandom_range(0, 299) != 0), a, ($urandom_range(0, 3) == 0), d,
          E'($urandom()), 1'($urandom()), 1'b0, 32'd0, "rand");
    end

    idle(); idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_hpm_counters.md
# ibex_hpm_counters

Parametrised machine performance-counter bank: `mcycle`, `minstret` and `MHPMCounterNum` configurable-width `mhpmcounter3+` counters, with `mhpmevent` event selection, `mcountinhibit` gating and per-counter overflow pulses. Sits beside the CSR file in the ID/EX stage and owns CSR addresses 0x320–0x33F, 0xB00–0xB1F and 0xB80–0xB9F. The CSR file forwards accesses to it and muxes its read data using `csr_hit_o`.

## Interface

**Parameters**
- `MHPMCounterNum`, default 8: number of implemented `mhpmcounter`s, 0–29. Counter k = 3..3+N-1.
- `MHPMCounterWidth`, default 40: width of each `mhpmcounter`, 33–64.
- `NumEvents`, default 16: number of event inputs, 1–32.

**Ports**
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. Synchronous, active-low. One clock domain.
- `csr_addr_i` in 12: CSR address.
- `csr_we_i` in 1: CSR write strobe. Already qualified by the CSR file; write data is final after set/clear resolution.
- `csr_wdata_i` in 32: CSR write data.
- `csr_rdata_o` out 32: read data for `csr_addr_i`. Combinational.
- `csr_hit_o` out 1: `csr_addr_i` is in this block's address range.
- `instr_ret_i` in 1: an instruction retires this cycle.
- `events_i` in NumEvents: HPM event strobes, one bit per event.
- `cnt_overflow_o` out MHPMCounterNum: one-cycle pulse when the corresponding `mhpmcounter` wraps.

## Operation

**Registers and reset values**
- All registers reset to 0: `mcycle`[63:0], `minstret`[63:0], `mhpmcounter`k[W-1:0], `mhpmevent`k[NumEvents-1:0], `mcountinhibit`.
- `cnt_overflow_o` resets to 0.

**Address map**
- 0x320: `mcountinhibit`.
- 0x323+i: `mhpmevent`(3+i).
- 0xB00 / 0xB80: `mcycle` low / high.
- 0xB02 / 0xB82: `minstret` low / high.
- 0xB03+i / 0xB83+i: `mhpmcounter` low / high.
- `csr_hit_o` = 1 for any address in 0x320–0x33F, 0xB00–0xB1F, 0xB80–0xB9F, including unimplemented slots.
- Outside those ranges: `csr_rdata_o` = 0 and writes are ignored.

**`mcountinhibit`**
- Implemented bits: 0 (CY), 2 (IR), and 3..3+N-1.
- All other bits, including bit 1, read 0 and ignore writes.

**`mhpmevent`k**
- Bitmask over `events_i`; bits ≥ NumEvents read 0.
- Counter k increments when `|(events_i & mhpmevent_k)` and its inhibit bit is clear.
- A mask of 0 means the counter never increments.

**Increment rules**
- `mcycle` increments every cycle while CY = 0.
- `minstret` increments on `instr_ret_i` while IR = 0.
- Increment is +1 modulo 2^width. `mcycle`/`minstret` are 64 bits; `mhpmcounter` is W bits.

**Read rules**
- Low half returns bits [31:0].
- High half returns bits [W-1:32], zero-extended to 32 bits.
- Unimplemented counter and event slots read 0 and ignore writes.

**Write rules**
- Low write loads [31:0]; the high bits are kept.
- High write loads [W-1:32] from `csr_wdata_i`[W-33:0]; the low bits are kept; upper write bits are dropped.
- A write takes priority over an increment on the same counter in the same cycle: that cycle's increment is lost, and there is no carry into the unwritten half.
- A write to `mcountinhibit` or `mhpmevent` takes effect on the next cycle's increment decision. The same-cycle decision uses the old value.

**Overflow**
- `cnt_overflow_o`[i] pulses when `mhpmcounter`(3+i) increments from all-ones to 0.
- A CSR write never produces an overflow pulse.

## Timing

- Every counter and config update happens on the `clk_i` rising edge following the cycle in which the event, retire or write is presented. There is no input registering.
- Read is zero-latency combinational from the current register value. A write is visible on `csr_rdata_o` from the next cycle.
- `cnt_overflow_o` is registered and high for exactly the one cycle after the wrapping edge.
- Reset (`rst_ni` = 0 sampled at an edge) overrides any concurrent write or increment. Mid-count reset yields all zeros at the next edge.
- Back-to-back writes (low then high) in consecutive cycles must not corrupt the other half, even when increments occur between them.

## Test plan

1. **Reset and free run.** Release reset and hold all CSR inputs idle for 10 cycles. Required: `mcycle` = 10, `minstret` = 0, all `mhpmcounter`s = 0; `cnt_overflow_o` stayed 0.
2. **Event selection.** Write `mhpmevent3` = 0x0005, then pulse `events_i`[0], [1] and [2] once each in separate cycles, plus `events_i`[0] and [2] together in one cycle. Required: `mhpmcounter3` = 3, all other counters = 0.
3. **Inhibit.** Write `mcountinhibit` = 0xFFFFFFFF and run 5 cycles. Required: `mcycle` is frozen; a read of 0x320 returns 0x000007FD (N = 8).
4. **Width and wrap.** Write 0xB83 = 0xFFFFFFFF (sets [39:32] to 0xFF), then 0xB03 = 0xFFFFFFFE, then present 2 selected events. Required: counter goes 0xFF_FFFFFFFF → 0; `cnt_overflow_o`[0] pulses for exactly 1 cycle; 0xB83 reads 0.
5. **Write/increment collision.** Keep an event asserted every cycle while writing 0xB03 = 0x100. Required: the next-cycle read is 0x100, and 0x101 the cycle after.
6. **Unmapped and unimplemented slots.** Read/write 0xB1F and 0x33F: required hit = 1, read 0 after write. Read 0x300: required hit = 0, rdata 0.
